jzjpcc_decode_execute_reg: RTL and testbench
============================================

JZJPCC_DECODE_EXECUTE_REG -- requirements
Module: jzjpcc_decode_execute_reg

Interface
REQ-001 Parameter: PC_MAX_B, default 31, MSB index of the word-aligned PC field (2 < PC_MAX_B <= 31).
REQ-002 clock  input  1  single clock for the block; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 stall  input  1  hold the execute-side contents this cycle.
REQ-005 flush  input  1  kill the execute-side instruction, inserting a bubble.
REQ-006 decodeValid  input  1  decode stage presents a real instruction.
REQ-007 decodeAluMuxMode  input  2  operand select: 00 rs1/rs2, 01 rs1/imm, 10 PC/4, 11 PC/imm.
REQ-008 decodeRs1, decodeRs2  input  32 each  register file read data.
REQ-009 decodeRs1Addr, decodeRs2Addr  input  5 each  source register indices.
REQ-010 decodeImmediate  input  32  sign-extended immediate.
REQ-011 decodePC  input  [PC_MAX_B:2]  word address of the instruction.
REQ-012 decodeRdAddr  input  5, decodeRdWrite  input  1  destination index and write intent.
REQ-013 fwdWrite  input  1, fwdAddr  input  5, fwdData  input  32  later-stage result being retired.
REQ-014 exValid  output  1, exAluMuxMode  output  2, exRs1/exRs2/exImmediate  output  32 each.
REQ-015 exCurrentPC  output  32, exRdAddr  output  5, exRdWrite  output  1  execute-stage view of the instruction.

Function
REQ-016 Latency: decode inputs appear on ex* outputs one clock after capture; no combinational path from decode* to ex*.
REQ-017 Capture: on a rising edge with reset=1, flush=0 and stall=0, every ex* register SHALL load its decode* counterpart.
REQ-018 Hold: with stall=1 and flush=0, every ex* register SHALL keep its value, except exRs1/exRs2 per REQ-021.
REQ-019 Flush: with flush=1, exValid and exRdWrite SHALL become 0 regardless of stall; other fields keep their values.
REQ-020 exRdWrite SHALL equal decodeRdWrite AND decodeValid at capture, so an invalid slot never requests a write.
REQ-021 Forwarding: on capture, exRs1 loads fwdData when fwdWrite=1, fwdAddr!=0 and fwdAddr==decodeRs1Addr; otherwise decodeRs1. Same rule for exRs2 with decodeRs2Addr. During hold, the rule compares against the internally held source addresses and updates the held exRs1/exRs2.
REQ-022 fwdAddr==0 SHALL never forward; both operands SHALL forward in the same cycle when both addresses match.
REQ-023 exCurrentPC SHALL equal {zeros, PC register, 2'b00}; bits 31:PC_MAX_B+1 and 1:0 are 0.
REQ-024 Priority: reset > flush > stall > capture.

Reset
REQ-025 On a rising edge with reset=0: exValid=0, exRdWrite=0, exAluMuxMode=2'b00, exRs1=exRs2=exImmediate=0, exCurrentPC=0, exRdAddr=0, held source addresses=0.
REQ-026 Reset asserted mid-stall or mid-flush SHALL take effect on that edge; the first capture occurs on the first edge with reset=1 and stall=0.

Configuration
REQ-027 Macro JZJPCC_DX_FORWARDING_EN: when defined, REQ-021/022 apply; when undefined, fwdWrite/fwdAddr/fwdData are ignored, exRs1/exRs2 load decodeRs1/decodeRs2 unchanged, and held operands do not change during stall.

Verification
REQ-028 Reset: drive reset=0 for 2 cycles with random decode inputs -> all outputs 0 after the first edge.
REQ-029 Pass-through: decodeValid=1, mode=2'b11, decodePC=0x100>>2 (PC_MAX_B=31), imm=0x10, rdAddr=5, rdWrite=1 -> next cycle exCurrentPC=0x100, exImmediate=0x10, exRdWrite=1.
REQ-030 Forwarding: decodeRs1Addr=3, decodeRs1=0x11, fwdWrite=1, fwdAddr=3, fwdData=0xAA -> exRs1=0xAA with macro defined, 0x11 without; with fwdAddr=0 -> 0x11.
REQ-031 Stall forwarding: capture rs2Addr=7, then stall=1 while fwdAddr=7, fwdData=0x55 -> exRs2=0x55 while all other outputs are unchanged.
REQ-032 Flush vs stall: stall=1 and flush=1 with exValid=1 -> exValid=0, exRdWrite=0 next cycle; other fields unchanged.
REQ-033 Invalid slot: decodeValid=0, decodeRdWrite=1 -> exValid=0, exRdWrite=0.

Source files
------------

// File: rtl/jzjpcc_decode_execute_reg.sv
// Decode-to-execute pipeline register with stall/flush and optional operand forwarding.
// Optional feature macro: JZJPCC_DX_FORWARDING_EN (retiring result forwarded into rs1/rs2).
module jzjpcc_decode_execute_reg #(
  parameter int PC_MAX_B = 31
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_decodeValid,
  input  logic [1:0]            i_decodeAluMuxMode,
  input  logic [31:0]           i_decodeRs1,
  input  logic [31:0]           i_decodeRs2,
  input  logic [4:0]            i_decodeRs1Addr,
  input  logic [4:0]            i_decodeRs2Addr,
  input  logic [31:0]           i_decodeImmediate,
  input  logic [PC_MAX_B:2]     i_decodePC,
  input  logic [4:0]            i_decodeRdAddr,
  input  logic                  i_decodeRdWrite,
  input  logic                  i_fwdWrite,
  input  logic [4:0]            i_fwdAddr,
  input  logic [31:0]           i_fwdData,
  output logic                  o_exValid,
  output logic [1:0]            o_exAluMuxMode,
  output logic [31:0]           o_exRs1,
  output logic [31:0]           o_exRs2,
  output logic [31:0]           o_exImmediate,
  output logic [31:0]           o_exCurrentPC,
  output logic [4:0]            o_exRdAddr,
  output logic                  o_exRdWrite
);

  logic                r_valid;
  logic [1:0]          r_mode;
  logic [31:0]         r_rs1;
  logic [31:0]         r_rs2;
  logic [4:0]          r_rs1_addr;
  logic [4:0]          r_rs2_addr;
  logic [31:0]         r_imm;
  logic [PC_MAX_B:2]   r_pc;
  logic [4:0]          r_rd_addr;
  logic                r_rd_write;

  logic [31:0]         w_rs1_cap;
  logic [31:0]         w_rs2_cap;
  logic [31:0]         w_rs1_hold;
  logic [31:0]         w_rs2_hold;

`ifdef JZJPCC_DX_FORWARDING_EN
  logic w_fwd_live;
  assign w_fwd_live = i_fwdWrite && (i_fwdAddr != 5'd0);

  assign w_rs1_cap  = (w_fwd_live && (i_fwdAddr == i_decodeRs1Addr)) ? i_fwdData : i_decodeRs1;
  assign w_rs2_cap  = (w_fwd_live && (i_fwdAddr == i_decodeRs2Addr)) ? i_fwdData : i_decodeRs2;
  // While stalled, a result retiring behind us must still reach the held operands.
  assign w_rs1_hold = (w_fwd_live && (i_fwdAddr == r_rs1_addr)) ? i_fwdData : r_rs1;
  assign w_rs2_hold = (w_fwd_live && (i_fwdAddr == r_rs2_addr)) ? i_fwdData : r_rs2;
`else
  logic w_unused_fwd;
  assign w_rs1_cap    = i_decodeRs1;
  assign w_rs2_cap    = i_decodeRs2;
  assign w_rs1_hold   = r_rs1;
  assign w_rs2_hold   = r_rs2;
  assign w_unused_fwd = ^{i_fwdWrite, i_fwdAddr, i_fwdData, r_rs1_addr, r_rs2_addr};
`endif

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_valid    <= 1'b0;
      r_mode     <= 2'b00;
      r_rs1      <= 32'h0;
      r_rs2      <= 32'h0;
      r_rs1_addr <= 5'd0;
      r_rs2_addr <= 5'd0;
      r_imm      <= 32'h0;
      r_pc       <= '0;
      r_rd_addr  <= 5'd0;
      r_rd_write <= 1'b0;
    end else if (i_flush) begin
      r_valid    <= 1'b0;
      r_rd_write <= 1'b0;
    end else if (i_stall) begin
      r_rs1      <= w_rs1_hold;
      r_rs2      <= w_rs2_hold;
    end else begin
      r_valid    <= i_decodeValid;
      r_mode     <= i_decodeAluMuxMode;
      r_rs1      <= w_rs1_cap;
      r_rs2      <= w_rs2_cap;
      r_rs1_addr <= i_decodeRs1Addr;
      r_rs2_addr <= i_decodeRs2Addr;
      r_imm      <= i_decodeImmediate;
      r_pc       <= i_decodePC;
      r_rd_addr  <= i_decodeRdAddr;
      r_rd_write <= i_decodeRdWrite && i_decodeValid;
    end
  end

  assign o_exValid      = r_valid;
  assign o_exAluMuxMode = r_mode;
  assign o_exRs1        = r_rs1;
  assign o_exRs2        = r_rs2;
  assign o_exImmediate  = r_imm;
  assign o_exCurrentPC  = 32'({r_pc, 2'b00});
  assign o_exRdAddr     = r_rd_addr;
  assign o_exRdWrite    = r_rd_write;

endmodule

// File: tb/tb_jzjpcc_decode_execute_reg.sv
// Table-driven bench for jzjpcc_decode_execute_reg; expectations follow JZJPCC_DX_FORWARDING_EN.
module tb_jzjpcc_decode_execute_reg;

`ifdef JZJPCC_DX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stl, fls, vld, wr, fw;
  logic [1:0]  mode;
  logic [31:0] rs1, rs2, imm, fd;
  logic [4:0]  a1, a2, rd, fa;
  logic [29:0] pc;
  logic        o_vld, o_wr;
  logic [1:0]  o_mode;
  logic [31:0] o_rs1, o_rs2, o_imm, o_pc;
  logic [4:0]  o_rd;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  jzjpcc_decode_execute_reg #(.PC_MAX_B(31)) dut (
    .i_clock(clk), .i_reset(rst), .i_stall(stl), .i_flush(fls),
    .i_decodeValid(vld), .i_decodeAluMuxMode(mode),
    .i_decodeRs1(rs1), .i_decodeRs2(rs2),
    .i_decodeRs1Addr(a1), .i_decodeRs2Addr(a2),
    .i_decodeImmediate(imm), .i_decodePC(pc),
    .i_decodeRdAddr(rd), .i_decodeRdWrite(wr),
    .i_fwdWrite(fw), .i_fwdAddr(fa), .i_fwdData(fd),
    .o_exValid(o_vld), .o_exAluMuxMode(o_mode),
    .o_exRs1(o_rs1), .o_exRs2(o_rs2), .o_exImmediate(o_imm),
    .o_exCurrentPC(o_pc), .o_exRdAddr(o_rd), .o_exRdWrite(o_wr)
  );

  typedef struct {
    logic rst, stl, fls, vld; logic [1:0] mode; logic [31:0] rs1, rs2;
    logic [4:0] a1, a2; logic [31:0] imm; logic [29:0] pc; logic [4:0] rd;
    logic wr, fw; logic [4:0] fa; logic [31:0] fd;
    logic e_vld; logic [1:0] e_mode; logic [31:0] e_rs1, e_rs2, e_imm, e_pc;
    logic [4:0] e_rd; logic e_wr;
  } vec_t;

  localparam int NV = 16;
  vec_t v [NV];

  task automatic apply(input vec_t t);
    rst = t.rst; stl = t.stl; fls = t.fls; vld = t.vld; mode = t.mode;
    rs1 = t.rs1; rs2 = t.rs2; a1 = t.a1; a2 = t.a2; imm = t.imm; pc = t.pc;
    rd = t.rd; wr = t.wr; fw = t.fw; fa = t.fa; fd = t.fd;
  endtask

  task automatic check(input string name, input vec_t t);
    n_total++;
    if ({o_vld, o_mode, o_rs1, o_rs2, o_imm, o_pc, o_rd, o_wr} ===
        {t.e_vld, t.e_mode, t.e_rs1, t.e_rs2, t.e_imm, t.e_pc, t.e_rd, t.e_wr})
      n_pass++;
    else
      $display("FAIL %s: got vld=%b mode=%0d rs1=%h rs2=%h imm=%h pc=%h rd=%0d wr=%b, want vld=%b mode=%0d rs1=%h rs2=%h imm=%h pc=%h rd=%0d wr=%b",
               name, o_vld, o_mode, o_rs1, o_rs2, o_imm, o_pc, o_rd, o_wr,
               t.e_vld, t.e_mode, t.e_rs1, t.e_rs2, t.e_imm, t.e_pc, t.e_rd, t.e_wr);
  endtask

  initial begin
    vec_t h;
    // rst stl fls vld mode rs1 rs2 a1 a2 imm pc rd wr fw fa fd | e_vld e_mode e_rs1 e_rs2 e_imm e_pc e_rd e_wr
    v[0]  = '{1'b0,1'b0,1'b0,1'b1,2'd3,32'hDEADBEEF,32'hCAFEF00D,5'd3,5'd4,32'h1234,30'h3FF,5'd9,1'b1,1'b1,5'd3,32'hAA,
              1'b0,2'd0,32'h0,32'h0,32'h0,32'h0,5'd0,1'b0};
    v[1]  = '{1'b0,1'b0,1'b0,1'b1,2'd1,32'h1111,32'h2222,5'd5,5'd6,32'hFFFF,30'h123,5'd2,1'b1,1'b0,5'd0,32'h0,
              1'b0,2'd0,32'h0,32'h0,32'h0,32'h0,5'd0,1'b0};
    v[2]  = '{1'b1,1'b0,1'b0,1'b1,2'd3,32'h1,32'h2,5'd1,5'd2,32'h10,30'h40,5'd5,1'b1,1'b0,5'd0,32'h0,
              1'b1,2'd3,32'h1,32'h2,32'h10,32'h100,5'd5,1'b1};
    v[3]  = '{1'b1,1'b0,1'b0,1'b1,2'd0,32'h11,32'h22,5'd3,5'd4,32'h0,30'h41,5'd6,1'b1,1'b1,5'd3,32'hAA,
              1'b1,2'd0,(FWD ? 32'hAA : 32'h11),32'h22,32'h0,32'h104,5'd6,1'b1};
    v[4]  = '{1'b1,1'b0,1'b0,1'b1,2'd1,32'h11,32'h33,5'd0,5'd0,32'h5,30'h42,5'd7,1'b0,1'b1,5'd0,32'hAA,
              1'b1,2'd1,32'h11,32'h33,32'h5,32'h108,5'd7,1'b0};
    v[5]  = '{1'b1,1'b0,1'b0,1'b1,2'd2,32'h1,32'h2,5'd9,5'd9,32'h0,30'h43,5'd8,1'b1,1'b1,5'd9,32'hBEEF,
              1'b1,2'd2,(FWD ? 32'hBEEF : 32'h1),(FWD ? 32'hBEEF : 32'h2),32'h0,32'h10C,5'd8,1'b1};
    v[6]  = '{1'b1,1'b0,1'b0,1'b1,2'd1,32'h66,32'h77,5'd6,5'd7,32'h99,30'h44,5'd10,1'b1,1'b0,5'd0,32'h0,
              1'b1,2'd1,32'h66,32'h77,32'h99,32'h110,5'd10,1'b1};
    v[7]  = '{1'b1,1'b1,1'b0,1'b0,2'd0,32'hEEEE,32'hFFFF,5'd7,5'd7,32'h1234,30'h200,5'd1,1'b0,1'b1,5'd7,32'h55,
              1'b1,2'd1,32'h66,(FWD ? 32'h55 : 32'h77),32'h99,32'h110,5'd10,1'b1};
    v[8]  = '{1'b1,1'b1,1'b0,1'b0,2'd2,32'hEEEE,32'hFFFF,5'd7,5'd7,32'h4321,30'h201,5'd2,1'b1,1'b1,5'd6,32'h61,
              1'b1,2'd1,(FWD ? 32'h61 : 32'h66),(FWD ? 32'h55 : 32'h77),32'h99,32'h110,5'd10,1'b1};
    v[9]  = '{1'b1,1'b1,1'b1,1'b1,2'd3,32'hEEEE,32'hFFFF,5'd6,5'd7,32'h4321,30'h202,5'd3,1'b1,1'b1,5'd6,32'h123,
              1'b0,2'd1,(FWD ? 32'h61 : 32'h66),(FWD ? 32'h55 : 32'h77),32'h99,32'h110,5'd10,1'b0};
    v[10] = '{1'b1,1'b0,1'b0,1'b0,2'd2,32'hA,32'hB,5'd1,5'd2,32'h3,30'h50,5'd4,1'b1,1'b0,5'd0,32'h0,
              1'b0,2'd2,32'hA,32'hB,32'h3,32'h140,5'd4,1'b0};
    v[11] = '{1'b1,1'b0,1'b0,1'b1,2'd1,32'h1,32'h2,5'd1,5'd2,32'h7,30'h60,5'd3,1'b1,1'b0,5'd0,32'h0,
              1'b1,2'd1,32'h1,32'h2,32'h7,32'h180,5'd3,1'b1};
    v[12] = '{1'b1,1'b0,1'b1,1'b1,2'd3,32'h9,32'h9,5'd9,5'd9,32'h9,30'h99,5'd9,1'b1,1'b1,5'd1,32'h9,
              1'b0,2'd1,32'h1,32'h2,32'h7,32'h180,5'd3,1'b0};
    v[13] = '{1'b0,1'b1,1'b1,1'b1,2'd3,32'h9,32'h9,5'd9,5'd9,32'h9,30'h99,5'd9,1'b1,1'b0,5'd0,32'h0,
              1'b0,2'd0,32'h0,32'h0,32'h0,32'h0,5'd0,1'b0};
    v[14] = '{1'b1,1'b1,1'b0,1'b1,2'd3,32'h9,32'h9,5'd5,5'd5,32'h9,30'h99,5'd9,1'b1,1'b1,5'd5,32'hFF,
              1'b0,2'd0,32'h0,32'h0,32'h0,32'h0,5'd0,1'b0};
    v[15] = '{1'b1,1'b0,1'b0,1'b1,2'd3,32'h5,32'h6,5'd5,5'd6,32'h8,30'h3FFFFFFF,5'd31,1'b1,1'b0,5'd0,32'h0,
              1'b1,2'd3,32'h5,32'h6,32'h8,32'hFFFFFFFC,5'd31,1'b1};

    apply(v[0]);
    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      apply(v[i]);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), v[i]);
    end

    // Changing decode inputs must not reach ex* before the next edge.
    h = v[15];
    h.vld = 1'b0; h.mode = 2'd0; h.rs1 = 32'h77; h.rs2 = 32'h88; h.a1 = 5'd2; h.a2 = 5'd3;
    h.imm = 32'h44; h.pc = 30'h1; h.rd = 5'd12; h.wr = 1'b1;
    apply(h);
    #1 check("no_comb_path", h);
    h.e_vld = 1'b0; h.e_mode = 2'd0; h.e_rs1 = 32'h77; h.e_rs2 = 32'h88;
    h.e_imm = 32'h44; h.e_pc = 32'h4; h.e_rd = 5'd12; h.e_wr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("latency_capture", h);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
